// File: rtl/bcd_mult_seq.sv
// bcd_mult_seq: sequential 8x8-digit packed BCD multiplier, one multiplier digit per MUL cycle
module bcd_mult_seq #(
    parameter bit FIXED_LATENCY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [63:0] p,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [63:0] acc_q, acc_d, p_q, p_d, row, acc_next;
    logic [2:0]  idx_q, idx_d;
    logic        err_q, err_d;

    function automatic logic has_bad_digit(input logic [31:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) bad = bad | (v[4*i +: 4] > 4'd9);
        return bad;
    endfunction

    function automatic logic [2:0] top_digit(input logic [31:0] v);
        logic [2:0] t;
        t = 3'd0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'd0) t = 3'(i);
        return t;
    endfunction

    // a times one BCD digit, ripple of per-digit products with a decimal carry; 9 digits, zero-extended
    function automatic logic [63:0] row_mul(input logic [31:0] v, input logic [3:0] m);
        logic [63:0] r;
        logic [6:0]  t;
        logic [3:0]  c;
        r = '0;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            t = 7'(v[4*i +: 4]) * 7'(m) + 7'(c);
            r[4*i +: 4] = 4'(t % 7'd10);
            c = 4'(t / 7'd10);
        end
        r[35:32] = c;
        return r;
    endfunction

    // 16-digit BCD add; carry out of the top digit cannot occur for valid operands
    function automatic logic [63:0] bcd_add(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] s;
        logic [4:0]  t;
        logic        c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            t = 5'(x[4*i +: 4]) + 5'(y[4*i +: 4]) + 5'(c);
            c = t > 5'd9;
            s[4*i +: 4] = c ? 4'(t - 5'd10) : t[3:0];
        end
        return s;
    endfunction

    assign row          = row_mul(a_q, b_q[4*idx_q +: 4]);
    assign acc_next     = bcd_add({acc_q[59:0], 4'd0}, row);
    assign start_ready  = state_q == IDLE;
    assign busy         = state_q != IDLE;
    assign result_valid = state_q == DONE;
    assign p            = p_q;
    assign err          = err_q;

    // next-state and datapath updates; p only changes on entry to DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        p_d     = p_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start_valid) begin
                a_d     = a;
                b_d     = b;
                acc_d   = '0;
                err_d   = 1'b0;
                state_d = CHECK;
            end
            CHECK: if (has_bad_digit(a_q) || has_bad_digit(b_q)) begin
                err_d   = 1'b1;
                p_d     = '0;
                state_d = DONE;
            end else if (!FIXED_LATENCY && b_q == 32'd0) begin
                p_d     = '0;
                state_d = DONE;
            end else begin
                idx_d   = FIXED_LATENCY ? 3'd7 : top_digit(b_q);
                state_d = MUL;
            end
            MUL: begin
                acc_d   = acc_next;
                idx_d   = idx_q - 3'd1;
                p_d     = idx_q == 3'd0 ? acc_next : p_q;
                state_d = idx_q == 3'd0 ? DONE : MUL;
            end
            DONE: state_d = result_ready ? IDLE : DONE;
        endcase
    end

    // state register with synchronous reset taking priority over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            err_q   <= err_d;
        end
    end
endmodule
